game_flow_controller: RTL and testbench

Parametrised top-level game-flow FSM for the ball-popping game: sequences welcome, play, pause, level transition, game-over and victory screens. It tracks lives and level, provides post-hit invulnerability and rope launch control, and drives player/ball movement and visibility enables to the drawing and object blocks. It sits between the keyboard decoder and collision detector on the input side and the player, rope, ball and screen-mux blocks on the output side.

---
 rtl/game_pkg.sv | 21 ++
 rtl/edge_detect.sv | 26 ++
 rtl/game_flow_controller.sv | 209 ++++++++++++++++++++
 tb/tb_game_flow_controller.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the ball-popping game flow controller.
//   GS_W            - width of the encoded game state
//   NUM_LIVES_DEF   - default number of lives at game start
//   NUM_LEVELS_DEF  - default number of levels to clear for victory
//   game_state_t    - encoded game screens (value seen on gameState)
package game_pkg;

  localparam int GS_W           = 3;
  localparam int NUM_LIVES_DEF  = 3;
  localparam int NUM_LEVELS_DEF = 4;

  typedef enum logic [GS_W-1:0] {
    GS_WELCOME   = 3'd0,
    GS_PLAY      = 3'd1,
    GS_PAUSE     = 3'd2,
    GS_LEVEL_UP  = 3'd3,
    GS_GAME_OVER = 3'd4,
    GS_VICTORY   = 3'd5
  } game_state_t;

endpackage

// File: rtl/edge_detect.sv
// edge_detect: one-flop rising-edge detector for a level key input.
//   clk    - system clock
//   resetN - asynchronous active-low reset
//   din    - level input (held = 1)
//   rise   - high in the first cycle din is seen high; a held key never retriggers
module edge_detect (
  input  logic clk,
  input  logic resetN,
  input  logic din,
  output logic rise
);

  logic prev_r;

  // Remember the previous cycle's key level
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      prev_r <= 1'b0;
    end else begin
      prev_r <= din;
    end
  end

  assign rise = din & ~prev_r;

endmodule

// File: rtl/game_flow_controller.sv
// game_flow_controller: top-level game-flow FSM (welcome/play/pause/level-up/
// game-over/victory), tracking lives, level, invulnerability and the rope.
//   Inputs : clk, resetN, rightArrow, leftArrow, spaceBar, pauseKey (level keys),
//            col_player_ball, all_balls_popped, rope_done, playerX
//   Outputs: gameState, lives, level, playerMoveRight/Left, ropeDeploy (pulse),
//            levelStart (pulse), playerVisible, ballVisible, invulnerable, ropeX
module game_flow_controller
  import game_pkg::*;
#(
  parameter int NUM_LIVES     = NUM_LIVES_DEF,
  parameter int NUM_LEVELS    = NUM_LEVELS_DEF,
  parameter int INVULN_CYCLES = 50_000_000,
  parameter int LEVEL_DELAY   = 100_000_000,
  parameter int X_W           = 11
) (
  input  logic            clk,
  input  logic            resetN,
  input  logic            rightArrow,
  input  logic            leftArrow,
  input  logic            spaceBar,
  input  logic            pauseKey,
  input  logic            col_player_ball,
  input  logic            all_balls_popped,
  input  logic            rope_done,
  input  logic [X_W-1:0]  playerX,
  output logic [GS_W-1:0] gameState,
  output logic [2:0]      lives,
  output logic [3:0]      level,
  output logic            playerMoveRight,
  output logic            playerMoveLeft,
  output logic            ropeDeploy,
  output logic            levelStart,
  output logic            playerVisible,
  output logic            ballVisible,
  output logic            invulnerable,
  output logic [X_W-1:0]  ropeX
);

  localparam int INV_W = $clog2(INVULN_CYCLES + 1);
  localparam int DLY_W = $clog2(LEVEL_DELAY + 1);

  localparam logic [GS_W-1:0] S_WELCOME   = GS_WELCOME;
  localparam logic [GS_W-1:0] S_PLAY      = GS_PLAY;
  localparam logic [GS_W-1:0] S_PAUSE     = GS_PAUSE;
  localparam logic [GS_W-1:0] S_LEVEL_UP  = GS_LEVEL_UP;
  localparam logic [GS_W-1:0] S_GAME_OVER = GS_GAME_OVER;
  localparam logic [GS_W-1:0] S_VICTORY   = GS_VICTORY;

  logic [GS_W-1:0]  state_r,       state_s;
  logic [2:0]       lives_r,       lives_s;
  logic [3:0]       level_r,       level_s;
  logic [X_W-1:0]   rope_x_r,      rope_x_s;
  logic             rope_active_r, rope_active_s;
  logic [INV_W-1:0] inv_cnt_r,     inv_cnt_s;
  logic             inv_active_r,  inv_active_s;
  logic [DLY_W-1:0] dly_cnt_r,     dly_cnt_s;
  logic             rope_deploy_s, level_start_s;
  logic             space_edge_s,  pause_edge_s, col_edge_s, hit_s, blink_s;

  edge_detect u_space (.clk(clk), .resetN(resetN), .din(spaceBar),        .rise(space_edge_s));
  edge_detect u_pause (.clk(clk), .resetN(resetN), .din(pauseKey),        .rise(pause_edge_s));
  edge_detect u_col   (.clk(clk), .resetN(resetN), .din(col_player_ball), .rise(col_edge_s));

  // A collision only costs a life on a new contact outside the invulnerable window
  assign hit_s = col_edge_s & ~inv_active_r & (lives_r != 3'd0);

  // Next-state and datapath update, collision > balls popped > pause > space
  always_comb begin
    state_s       = state_r;
    lives_s       = lives_r;
    level_s       = level_r;
    rope_x_s      = rope_x_r;
    rope_active_s = rope_active_r & ~rope_done;
    inv_cnt_s     = inv_cnt_r;
    inv_active_s  = inv_active_r;
    dly_cnt_s     = dly_cnt_r;
    rope_deploy_s = 1'b0;
    level_start_s = 1'b0;
    case (state_r)
      S_WELCOME: begin
        if (space_edge_s) begin
          state_s       = S_PLAY;
          lives_s       = 3'(NUM_LIVES);
          level_s       = 4'd0;
          level_start_s = 1'b1;
          rope_active_s = 1'b0;
          inv_cnt_s     = INV_W'(0);
          inv_active_s  = 1'b0;
        end else begin
          state_s = S_WELCOME;
        end
      end
      S_PLAY: begin
        // The window covers counts INVULN_CYCLES-1 down to 0 inclusive
        if (inv_active_r) begin
          if (inv_cnt_r == INV_W'(0)) begin
            inv_active_s = 1'b0;
          end else begin
            inv_cnt_s = inv_cnt_r - INV_W'(1);
          end
        end else begin
          inv_active_s = 1'b0;
        end
        if (hit_s) begin
          lives_s = lives_r - 3'd1;
          if (lives_r == 3'd1) begin
            state_s      = S_GAME_OVER;
            inv_cnt_s    = INV_W'(0);
            inv_active_s = 1'b0;
          end else begin
            inv_cnt_s    = INV_W'(INVULN_CYCLES - 1);
            inv_active_s = 1'b1;
          end
        end else if (all_balls_popped) begin
          if (level_r == 4'(NUM_LEVELS - 1)) begin
            state_s = S_VICTORY;
          end else begin
            state_s       = S_LEVEL_UP;
            level_s       = level_r + 4'd1;
            dly_cnt_s     = DLY_W'(LEVEL_DELAY - 1);
            rope_active_s = 1'b0;
            inv_cnt_s     = INV_W'(0);
            inv_active_s  = 1'b0;
          end
        end else if (pause_edge_s) begin
          state_s = S_PAUSE;
        end else if (space_edge_s && !rope_active_r) begin
          rope_deploy_s = 1'b1;
          rope_x_s      = playerX;
          rope_active_s = 1'b1;
        end else begin
          state_s = S_PLAY;
        end
      end
      S_PAUSE: begin
        if (pause_edge_s) begin
          state_s = S_PLAY;
        end else begin
          state_s = S_PAUSE;
        end
      end
      S_LEVEL_UP: begin
        if (dly_cnt_r == DLY_W'(0)) begin
          state_s       = S_PLAY;
          level_start_s = 1'b1;
        end else begin
          dly_cnt_s = dly_cnt_r - DLY_W'(1);
        end
      end
      S_GAME_OVER, S_VICTORY: begin
        if (space_edge_s) begin
          state_s = S_WELCOME;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = S_WELCOME;
      end
    endcase
  end

  // Game state registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r       <= S_WELCOME;
      lives_r       <= 3'd0;
      level_r       <= 4'd0;
      rope_x_r      <= X_W'(0);
      rope_active_r <= 1'b0;
      inv_cnt_r     <= INV_W'(0);
      inv_active_r  <= 1'b0;
      dly_cnt_r     <= DLY_W'(0);
    end else begin
      state_r       <= state_s;
      lives_r       <= lives_s;
      level_r       <= level_s;
      rope_x_r      <= rope_x_s;
      rope_active_r <= rope_active_s;
      inv_cnt_r     <= inv_cnt_s;
      inv_active_r  <= inv_active_s;
      dly_cnt_r     <= dly_cnt_s;
    end
  end

  // Blink uses counter bit 22; short windows have no such bit and never blink
  generate
    if (INV_W > 22) begin : g_blink
      assign blink_s = inv_cnt_r[22];
    end else begin : g_no_blink
      assign blink_s = 1'b0;
    end
  endgenerate

  assign gameState       = state_r;
  assign lives           = lives_r;
  assign level           = level_r;
  assign ropeX           = rope_x_r;
  assign invulnerable    = inv_active_r;
  assign ropeDeploy      = rope_deploy_s;
  assign levelStart      = level_start_s;
  assign playerMoveRight = (state_r == S_PLAY) & rightArrow & ~leftArrow;
  assign playerMoveLeft  = (state_r == S_PLAY) & leftArrow & ~rightArrow;
  assign playerVisible   = ((state_r == S_PLAY) | (state_r == S_PAUSE)) &
                           (~inv_active_r | ~blink_s);
  assign ballVisible     = (state_r == S_PLAY) | (state_r == S_PAUSE) |
                           (state_r == S_LEVEL_UP);

endmodule

// File: tb/tb_game_flow_controller.sv
// tb_game_flow_controller: directed self-checking bench for game_flow_controller
// with INVULN_CYCLES=8 and LEVEL_DELAY=6. Inputs change 1 time unit after a
// rising clock edge; outputs are checked 1 unit later, well away from the edge.
module tb_game_flow_controller;

  localparam int X_W = 11;

  logic           clk = 1'b0;
  logic           resetN;
  logic           rightArrow, leftArrow, spaceBar, pauseKey;
  logic           col_player_ball, all_balls_popped, rope_done;
  logic [X_W-1:0] playerX;
  logic [2:0]     gameState;
  logic [2:0]     lives;
  logic [3:0]     level;
  logic           playerMoveRight, playerMoveLeft, ropeDeploy, levelStart;
  logic           playerVisible, ballVisible, invulnerable;
  logic [X_W-1:0] ropeX;

  int n_cmp = 0;
  int n_bad = 0;

  // collision pattern and expectations per cycle after the first hit
  int col_pat   [0:10] = '{1, 1, 1, 0, 0, 1, 0, 0, 0, 1, 0};
  int exp_inv   [0:10] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1};
  int exp_lives [0:10] = '{3, 2, 2, 2, 2, 2, 2, 2, 2, 2, 1};

  always #5 clk = ~clk;

  game_flow_controller #(
    .NUM_LIVES(3), .NUM_LEVELS(4), .INVULN_CYCLES(8), .LEVEL_DELAY(6), .X_W(X_W)
  ) dut (
    .clk(clk), .resetN(resetN),
    .rightArrow(rightArrow), .leftArrow(leftArrow), .spaceBar(spaceBar), .pauseKey(pauseKey),
    .col_player_ball(col_player_ball), .all_balls_popped(all_balls_popped),
    .rope_done(rope_done), .playerX(playerX),
    .gameState(gameState), .lives(lives), .level(level),
    .playerMoveRight(playerMoveRight), .playerMoveLeft(playerMoveLeft),
    .ropeDeploy(ropeDeploy), .levelStart(levelStart),
    .playerVisible(playerVisible), .ballVisible(ballVisible),
    .invulnerable(invulnerable), .ropeX(ropeX)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetN = 1'b0; rightArrow = 1'b0; leftArrow = 1'b0; spaceBar = 1'b0; pauseKey = 1'b0;
    col_player_ball = 1'b0; all_balls_popped = 1'b0; rope_done = 1'b0; playerX = 11'd0;
    #12;
    check_val("rst_state", 32'(gameState), 32'd0);
    check_val("rst_lives", 32'(lives), 32'd0);
    check_val("rst_level", 32'(level), 32'd0);
    check_val("rst_ropex", 32'(ropeX), 32'd0);
    check_val("rst_pvis", 32'(playerVisible), 32'd0);
    check_val("rst_bvis", 32'(ballVisible), 32'd0);
    check_val("rst_inv", 32'(invulnerable), 32'd0);
    #10 resetN = 1'b1;
    step();

    // start game
    spaceBar = 1'b1; #1;
    check_val("start_lvlstart", 32'(levelStart), 32'd1);
    check_val("start_state_pre", 32'(gameState), 32'd0);
    step();
    check_val("start_state", 32'(gameState), 32'd1);
    check_val("start_lives", 32'(lives), 32'd3);
    check_val("start_level", 32'(level), 32'd0);
    check_val("start_lvlstart_end", 32'(levelStart), 32'd0);
    check_val("play_pvis", 32'(playerVisible), 32'd1);
    check_val("play_bvis", 32'(ballVisible), 32'd1);
    for (int i = 0; i < 10; i++) begin
      check_val("held_space_deploy", 32'(ropeDeploy), 32'd0);
      step();
    end
    spaceBar = 1'b0;
    rightArrow = 1'b1; #1;
    check_val("move_r", 32'(playerMoveRight), 32'd1);
    check_val("move_r_l", 32'(playerMoveLeft), 32'd0);
    leftArrow = 1'b1; #1;
    check_val("move_both_r", 32'(playerMoveRight), 32'd0);
    check_val("move_both_l", 32'(playerMoveLeft), 32'd0);
    rightArrow = 1'b0; #1;
    check_val("move_l", 32'(playerMoveLeft), 32'd1);
    leftArrow = 1'b0;
    step();

    // rope deploy
    playerX = 11'd320; spaceBar = 1'b1; #1;
    check_val("deploy1", 32'(ropeDeploy), 32'd1);
    step();
    check_val("deploy1_end", 32'(ropeDeploy), 32'd0);
    check_val("ropex1", 32'(ropeX), 32'd320);
    spaceBar = 1'b0;
    step();
    spaceBar = 1'b1; playerX = 11'd500; #1;
    check_val("deploy_busy", 32'(ropeDeploy), 32'd0);
    step();
    check_val("ropex_busy", 32'(ropeX), 32'd320);
    spaceBar = 1'b0; rope_done = 1'b1;
    step();
    rope_done = 1'b0;
    step();
    spaceBar = 1'b1; #1;
    check_val("deploy2", 32'(ropeDeploy), 32'd1);
    step();
    check_val("ropex2", 32'(ropeX), 32'd500);
    spaceBar = 1'b0; rope_done = 1'b1;
    step();
    rope_done = 1'b0;
    step();

    // collisions: hit at k=0, ignored edge at k=5, hit at k=9
    for (int k = 0; k <= 10; k++) begin
      col_player_ball = col_pat[k][0]; #1;
      check_val("col_inv", 32'(invulnerable), 32'(exp_inv[k]));
      check_val("col_lives", 32'(lives), 32'(exp_lives[k]));
      step();
    end
    step();
    step();

    // pause with invulnerability count at 4; window resumes afterwards
    pauseKey = 1'b1; rightArrow = 1'b1; #1;
    check_val("prepause_state", 32'(gameState), 32'd1);
    step();
    for (int i = 0; i < 20; i++) begin
      pauseKey = 1'b0;
      spaceBar = (i == 5) ? 1'b1 : 1'b0; #1;
      check_val("pause_state", 32'(gameState), 32'd2);
      check_val("pause_move", 32'(playerMoveRight), 32'd0);
      check_val("pause_deploy", 32'(ropeDeploy), 32'd0);
      check_val("pause_inv", 32'(invulnerable), 32'd1);
      step();
    end
    pauseKey = 1'b1; #1;
    check_val("pause_last", 32'(gameState), 32'd2);
    step();
    pauseKey = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_val("resume_state", 32'(gameState), 32'd1);
      check_val("resume_inv", 32'(invulnerable), 32'd1);
      check_val("resume_move", 32'(playerMoveRight), 32'd1);
      step();
    end
    #1;
    check_val("inv_expired", 32'(invulnerable), 32'd0);

    // last life lost while balls popped: collision wins
    rightArrow = 1'b0; col_player_ball = 1'b1; all_balls_popped = 1'b1;
    step();
    check_val("gameover_state", 32'(gameState), 32'd4);
    check_val("gameover_lives", 32'(lives), 32'd0);
    check_val("gameover_pvis", 32'(playerVisible), 32'd0);
    check_val("gameover_bvis", 32'(ballVisible), 32'd0);
    col_player_ball = 1'b0; all_balls_popped = 1'b0;
    step();
    spaceBar = 1'b1;
    step();
    check_val("gameover_to_welcome", 32'(gameState), 32'd0);
    spaceBar = 1'b0;
    step();

    // new game and level transitions
    spaceBar = 1'b1; #1;
    check_val("restart_lvlstart", 32'(levelStart), 32'd1);
    step();
    check_val("restart_lives", 32'(lives), 32'd3);
    check_val("restart_level", 32'(level), 32'd0);
    spaceBar = 1'b0;
    step();
    all_balls_popped = 1'b1;
    step();
    all_balls_popped = 1'b0;
    for (int j = 0; j < 6; j++) begin
      #1;
      check_val("lvlup_state", 32'(gameState), 32'd3);
      check_val("lvlup_start", 32'(levelStart), (j == 5) ? 32'd1 : 32'd0);
      check_val("lvlup_bvis", 32'(ballVisible), 32'd1);
      check_val("lvlup_level", 32'(level), 32'd1);
      step();
    end
    check_val("lvlup_back_state", 32'(gameState), 32'd1);
    check_val("lvlup_back_start", 32'(levelStart), 32'd0);
    for (int lv = 2; lv <= 3; lv++) begin
      all_balls_popped = 1'b1;
      step();
      all_balls_popped = 1'b0;
      repeat (6) step();
      check_val("lvl_n_state", 32'(gameState), 32'd1);
      check_val("lvl_n_level", 32'(level), 32'(lv));
    end
    all_balls_popped = 1'b1;
    step();
    check_val("victory_state", 32'(gameState), 32'd5);
    check_val("victory_level", 32'(level), 32'd3);
    all_balls_popped = 1'b0;
    spaceBar = 1'b1;
    step();
    check_val("victory_to_welcome", 32'(gameState), 32'd0);
    spaceBar = 1'b0;
    step();

    // asynchronous reset mid-PLAY
    spaceBar = 1'b1;
    step();
    spaceBar = 1'b0;
    step();
    playerX = 11'd77; spaceBar = 1'b1; #1;
    check_val("deploy3", 32'(ropeDeploy), 32'd1);
    step();
    check_val("ropex3", 32'(ropeX), 32'd77);
    spaceBar = 1'b0; rightArrow = 1'b1; #1;
    check_val("premrst_move", 32'(playerMoveRight), 32'd1);
    resetN = 1'b0; #1;
    check_val("mrst_state", 32'(gameState), 32'd0);
    check_val("mrst_lives", 32'(lives), 32'd0);
    check_val("mrst_ropex", 32'(ropeX), 32'd0);
    check_val("mrst_move", 32'(playerMoveRight), 32'd0);
    check_val("mrst_pvis", 32'(playerVisible), 32'd0);
    check_val("mrst_bvis", 32'(ballVisible), 32'd0);
    rightArrow = 1'b0;
    step();
    resetN = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
